core_seq: RTL



---
 rtl/core_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/core_seq.sv
// rtl/core_seq.sv - Multi-cycle fetch/decode/execute sequencer for the RV32 core
// Owns pc and the latched instruction; halts on ebreak or fetch timeout.
module core_seq #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst_q,
    input  logic        is_ebreak,
    output logic        exu_start,
    input  logic        exu_done,
    input  logic [31:0] next_pc,
    output logic        gpr_we,
    output logic [31:0] pc,
    output logic        halt,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] wait_cnt;
    logic        accept;
    logic        load_inst;
    logic        commit;
    logic        set_halt;
    logic        set_err;

    assign imem_req_addr = pc;

    always_comb begin
        state_nx       = state;
        imem_req_valid = 1'b0;
        exu_start      = 1'b0;
        gpr_we         = 1'b0;
        accept         = 1'b0;
        load_inst      = 1'b0;
        commit         = 1'b0;
        set_halt       = 1'b0;
        set_err        = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    accept   = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response wins over a timeout landing in the same cycle.
                if (imem_rsp_valid) begin
                    load_inst = 1'b1;
                    state_nx  = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    set_halt = 1'b1;
                    set_err  = 1'b1;
                    state_nx = S_HALT;
                end
            end
            S_DECODE: begin
                if (is_ebreak) begin
                    set_halt = 1'b1;
                    state_nx = S_HALT;
                end else begin
                    exu_start = 1'b1;
                    state_nx  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exu_done) begin
                    gpr_we   = 1'b1;
                    commit   = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_FETCH;
            end
        endcase
        // Strobes stay quiet while reset is held, whatever state we were in.
        if (!rst) begin
            imem_req_valid = 1'b0;
            exu_start      = 1'b0;
            gpr_we         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            inst_q   <= '0;
            wait_cnt <= '0;
            halt     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (load_inst) begin
                inst_q <= imem_rsp_data;
            end
            if (commit) begin
                pc <= next_pc;
            end
            if (set_halt) begin
                halt <= 1'b1;
            end
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule
